shifter: RTL and testbench

//  - Single-bit shift unit feeding the ALU B-operand path of the datapath.
//  - Combinational result `out` = in shifted per 2-bit `shift` code (pass, LSL, LSR, ASR).
//  - Also provides a registered copy `out_r` for pipelined consumers.
//  - Clocked on clk; asynchronous active-high reset.

---
 rtl/alu_pkg.sv | 14 +
 rtl/shifter_core.sv | 53 +++++
 rtl/shifter.sv | 73 +++++++
 tb/tb_shifter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift-op encoding and default datapath width.
// Imported by the shifter core and the shifter top.
package alu_pkg;

  localparam int SH_WIDTH = 16;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_e;

endpackage

// File: rtl/shifter_core.sv
// Combinational single-bit shift mux for the ALU B-operand path.
// Carry-out port exists only when SHIFTER_FLAGS_EN is defined.
module shifter_core
  import alu_pkg::*;
#(
  parameter int WIDTH = SH_WIDTH
) (
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
`ifdef SHIFTER_FLAGS_EN
  output logic             co,
`endif
  output logic [WIDTH-1:0] out
);

  logic co_int;

  // Decode all four ops; an unknown op propagates X rather than a guess
  always_comb begin
    out    = 'x;
    co_int = 1'bx;
    unique case (shift)
      SH_NONE: begin
        out    = in;
        co_int = 1'b0;
      end
      SH_LSL: begin
        out    = {in[WIDTH-2:0], 1'b0};
        co_int = in[WIDTH-1];
      end
      SH_LSR: begin
        out    = {1'b0, in[WIDTH-1:1]};
        co_int = in[0];
      end
      SH_ASR: begin
        out    = {in[WIDTH-1], in[WIDTH-1:1]};
        co_int = in[0];
      end
      default: begin
        out    = 'x;
        co_int = 1'bx;
      end
    endcase
  end

`ifdef SHIFTER_FLAGS_EN
  assign co = co_int;
`else
  logic unused_co;
  assign unused_co = co_int;
`endif

endmodule

// File: rtl/shifter.sv
// Shift unit top: combinational result plus a 1-cycle registered copy.
// Optional flags (co, zero and registered copies) under SHIFTER_FLAGS_EN.
module shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = SH_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
`ifdef SHIFTER_FLAGS_EN
  output logic             co,
  output logic             zero,
  output logic             co_r,
  output logic             zero_r,
`endif
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_r
);

  logic [WIDTH-1:0] out_r_d, out_r_q;

  shifter_core #(.WIDTH(WIDTH)) u_core (
    .in    (in),
    .shift (shift),
`ifdef SHIFTER_FLAGS_EN
    .co    (co),
`endif
    .out   (out)
  );

`ifdef SHIFTER_FLAGS_EN
  logic co_r_d, co_r_q;
  logic zero_r_d, zero_r_q;

  assign zero = (out == '0);

  // Next values for the registered flags track the live flags
  always_comb begin
    co_r_d   = co;
    zero_r_d = zero;
  end

  // Flag registers share the async reset of the data register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      co_r_q   <= 1'b0;
      zero_r_q <= 1'b0;
    end else begin
      co_r_q   <= co_r_d;
      zero_r_q <= zero_r_d;
    end
  end

  assign co_r   = co_r_q;
  assign zero_r = zero_r_q;
`endif

  // Registered copy simply samples the combinational result
  always_comb begin
    out_r_d = out;
  end

  // Output register, cleared immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_r_q <= '0;
    else       out_r_q <= out_r_d;
  end

  assign out_r = out_r_q;

endmodule

// File: tb/tb_shifter.sv
// Directed self-checking bench for shifter (WIDTH=16).
// Flag checks are compiled in when SHIFTER_FLAGS_EN is defined.
module tb_shifter;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic [1:0]  shift;
  logic [15:0] out;
  logic [15:0] out_r;
`ifdef SHIFTER_FLAGS_EN
  logic co, zero, co_r, zero_r;
`endif

  int checks = 0;
  int errors = 0;

  shifter #(.WIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .in     (in),
    .shift  (shift),
`ifdef SHIFTER_FLAGS_EN
    .co     (co),
    .zero   (zero),
    .co_r   (co_r),
    .zero_r (zero_r),
`endif
    .out    (out),
    .out_r  (out_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_shift(input logic [15:0] a,
                                            input logic [1:0] op);
    logic signed [15:0] s;
    s = a;
    case (op)
      2'd0:    return a;
      2'd1:    return a << 1;
      2'd2:    return a >> 1;
      default: return 16'(s >>> 1);
    endcase
  endfunction

  task automatic apply(input string tag,
                       input logic [15:0] a,
                       input logic [1:0] op,
                       input logic [15:0] exp);
    @(negedge clk);
    in    = a;
    shift = op;
    #1;
    chk({tag, "_out"}, out, exp);
    @(posedge clk);
    #1;
    chk({tag, "_out_r"}, out_r, exp);
  endtask

  initial begin
    logic [15:0] prev;
    logic [15:0] a;
    logic [1:0]  op;

    reset = 1'b1;
    in    = 16'd100;
    shift = 2'b00;
    #1;
    chk("rst_out_r", out_r, 16'h0000);
    chk("rst_out_comb", out, 16'd100);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_held", out_r, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    apply("pass100", 16'd100, 2'b00, 16'd100);
    apply("lsl100", 16'd100, 2'b01, 16'd200);
    apply("lsl8000", 16'h8000, 2'b01, 16'h0000);
`ifdef SHIFTER_FLAGS_EN
    chk("lsl8000_co_r", {15'd0, co_r}, 16'd1);
    chk("lsl8000_zero_r", {15'd0, zero_r}, 16'd1);
`endif
    apply("lsr100", 16'd100, 2'b10, 16'd50);
    apply("lsr99", 16'd99, 2'b10, 16'd49);
    apply("lsr1", 16'd1, 2'b10, 16'd0);
`ifdef SHIFTER_FLAGS_EN
    chk("lsr1_co", {15'd0, co}, 16'd1);
    chk("lsr1_zero", {15'd0, zero}, 16'd1);
`endif
    apply("asr0001", 16'h0001, 2'b11, 16'h0000);
    apply("asrffff", 16'hFFFF, 2'b11, 16'hFFFF);
`ifdef SHIFTER_FLAGS_EN
    chk("asrffff_zero", {15'd0, zero}, 16'd0);
    chk("asrffff_co", {15'd0, co}, 16'd1);
`endif
    apply("asr8000", 16'h8000, 2'b11, 16'hC000);

    // Mid-run reset while out_r holds C000
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_out_r", out_r, 16'h0000);
`ifdef SHIFTER_FLAGS_EN
    chk("midrst_co_r", {15'd0, co_r}, 16'd0);
`endif
    in    = 16'd100;
    shift = 2'b01;
    #1;
    chk("midrst_out", out, 16'd200);
    @(posedge clk);
    #1;
    chk("midrst_hold", out_r, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("release_out_r", out_r, 16'd200);

    // Random sweep against reference model
    prev = 16'd200;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      a     = 16'($urandom);
      op    = 2'(i % 4);
      in    = a;
      shift = op;
      #1;
      chk("rnd_out", out, ref_shift(a, op));
      prev = ref_shift(a, op);
      @(posedge clk);
      #1;
      chk("rnd_out_r", out_r, prev);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
